// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-side memory responder: FSM state encoding,
// SRAM transfer size codes and a small popcount helper.
package dmem_responder_pkg;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_REQ  = 2'd1;
    localparam logic [1:0] DMEM_WAIT = 2'd2;
    localparam logic [1:0] DMEM_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] PEND_MAX = 2'd3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/dmem_responder_size_dec.sv
// Byte-enable to SRAM size decoder; partial-word masks such as 0111/1110
// fall through to a full-word transfer and rely on the strobes.
module dmem_size_dec
    import dmem_responder_pkg::*;
(
    input  logic [3:0] sel,
    output logic [1:0] size
);

    always_comb begin
        size = SZ_WORD;
        if (popcount4(sel) == 3'd1) begin
            size = SZ_BYTE;
        end else if (sel == 4'b0011 || sel == 4'b1100) begin
            size = SZ_HALF;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage to SRAM-like req/addr_ok/data_ok bridge with flush absorption.
// Optional macro DMEM_POSTED_WRITE_EN: stores complete on addr_ok.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_w_data,
    input  logic [3:0]        mem_sel,
    input  logic              flush,
    output logic              mem_available,
    output logic [DATA_W-1:0] mem_r_data,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              cancel;
    logic              cancel_eff;
    logic              accept;
    logic              addr_hs;
    logic              bus_done;
    logic              load_done;
    logic              can_accept;
    logic              posted;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        sel_q;
    logic [1:0]        size_q;
    logic [1:0]        sel_size;

    dmem_size_dec u_size_dec (
        .sel  (mem_sel),
        .size (sel_size)
    );

    // A flush in the completing cycle counts as well, the instruction is gone either way
    assign cancel_eff = cancel | flush;
    assign addr_hs    = (state == DMEM_REQ) && data_sram_addr_ok;
    assign bus_done   = (addr_hs || state == DMEM_WAIT) && data_sram_data_ok;
    assign load_done  = bus_done && !wr_q && !cancel_eff;

`ifdef DMEM_POSTED_WRITE_EN
    logic [1:0] pend;
    logic       pend_inc;
    logic       pend_dec;

    // Loads only issue with no writes in flight, so any data_ok seen while
    // pend is non-zero (or alongside a write handshake) is a write ack.
    assign posted     = wr_q;
    assign pend_inc   = addr_hs && wr_q;
    assign pend_dec   = data_sram_data_ok && (pend != 2'd0 || pend_inc);
    assign can_accept = mem_w_en ? (pend != PEND_MAX) : (pend == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 2'd0;
        end else if (pend_inc && !pend_dec) begin
            pend <= pend + 2'd1;
        end else if (!pend_inc && pend_dec) begin
            pend <= pend - 2'd1;
        end
    end
`else
    assign posted     = 1'b0;
    assign can_accept = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if ((mem_r_en || mem_w_en) && !flush && can_accept) begin
                    accept    = 1'b1;
                    state_nxt = DMEM_REQ;
                end
            end
            DMEM_REQ: begin
                if (data_sram_addr_ok) begin
                    if (posted) begin
                        state_nxt = DMEM_DONE;
                    end else if (data_sram_data_ok) begin
                        state_nxt = cancel_eff ? DMEM_IDLE : DMEM_DONE;
                    end else begin
                        state_nxt = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (data_sram_data_ok) begin
                    state_nxt = cancel_eff ? DMEM_IDLE : DMEM_DONE;
                end
            end
            default: begin
                state_nxt = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DMEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus fields come only from these registers so they hold steady until addr_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 4'b0000;
            size_q  <= SZ_BYTE;
        end else if (accept) begin
            wr_q    <= mem_w_en;
            addr_q  <= mem_addr;
            wdata_q <= mem_w_data;
            sel_q   <= mem_sel;
            size_q  <= sel_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel <= 1'b0;
        end else if (state == DMEM_IDLE) begin
            cancel <= 1'b0;
        end else if (flush && (state == DMEM_REQ || state == DMEM_WAIT)) begin
            cancel <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r_data <= '0;
        end else if (load_done) begin
            mem_r_data <= data_sram_rdata;
        end
    end

    assign mem_available   = (state == DMEM_DONE);
    assign data_sram_req   = (state == DMEM_REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;
    assign data_sram_wstrb = wr_q ? sel_q : 4'b0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores against a simple
// in-order SRAM slave with programmable addr_ok/data_ok delays.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_w_data = '0;
    logic [3:0]  mem_sel = '0;
    logic        flush = 1'b0;
    logic        mem_available;
    logic [31:0] mem_r_data;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        check_data;
        logic [31:0] data;
    } resp_exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } slave_resp_t;

    bus_exp_t    bus_q[$];
    resp_exp_t   resp_q[$];
    slave_resp_t slave_q[$];

    int          addr_delay = 0;
    int          data_delay = 1;
    logic [31:0] slave_rdata = '0;
    int          slave_cyc = 0;
    int          wait_cnt = 0;

    dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_r_en          (mem_r_en),
        .mem_w_en          (mem_w_en),
        .mem_addr          (mem_addr),
        .mem_w_data        (mem_w_data),
        .mem_sel           (mem_sel),
        .flush             (flush),
        .mem_available     (mem_available),
        .mem_r_data        (mem_r_data),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // In-order slave: addr_ok after addr_delay cycles of req, data_ok data_delay cycles later
    always @(negedge clk) begin
        slave_cyc++;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        if (data_sram_req && !rst) begin
            if (wait_cnt >= addr_delay) begin
                data_sram_addr_ok = 1'b1;
                slave_q.push_back('{due: slave_cyc + data_delay, data: slave_rdata});
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (slave_q.size() > 0 && slave_cyc >= slave_q[0].due) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = slave_q[0].data;
            void'(slave_q.pop_front());
        end
    end

    logic        prev_req = 1'b0;
    bus_exp_t    snap;

    always @(negedge clk) begin
        bus_exp_t  be;
        resp_exp_t re;
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (data_sram_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL extra_req: got req at addr %h, expected none", data_sram_addr);
                end else begin
                    be = bus_q.pop_front();
                    checkOutput("req_wr", 32'(data_sram_wr), 32'(be.wr));
                    checkOutput("req_size", 32'(data_sram_size), 32'(be.size));
                    checkOutput("req_addr", data_sram_addr, be.addr);
                    checkOutput("req_wstrb", 32'(data_sram_wstrb), 32'(be.wstrb));
                    if (be.wr) checkOutput("req_wdata", data_sram_wdata, be.wdata);
                    snap = be;
                end
            end else if (data_sram_req) begin
                checkOutput("hold_addr", data_sram_addr, snap.addr);
                checkOutput("hold_wstrb", 32'(data_sram_wstrb), 32'(snap.wstrb));
                if (snap.wr) checkOutput("hold_wdata", data_sram_wdata, snap.wdata);
            end
            prev_req = data_sram_req;
            if (mem_available) begin
                if (resp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL extra_pulse: got mem_available=1, expected 0");
                end else begin
                    re = resp_q.pop_front();
                    if (re.check_data) checkOutput("r_data", mem_r_data, re.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] sel,
                                 input logic [1:0] exp_size, input int a_dly, input int d_dly,
                                 input logic [31:0] rdata, input int flush_cyc, input int exp_lat);
        bit seen = 0;
        int lat = 0;
        addr_delay  = a_dly;
        data_delay  = d_dly;
        slave_rdata = rdata;
        bus_q.push_back('{wr: wr_en, size: exp_size, addr: addr,
                          wstrb: (wr_en ? sel : 4'b0000), wdata: wdata});
        if (flush_cyc < 0) resp_q.push_back('{check_data: !wr_en, data: rdata});
        @(negedge clk);
        mem_r_en   = rd_en;
        mem_w_en   = wr_en;
        mem_addr   = addr;
        mem_w_data = wdata;
        mem_sel    = sel;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            flush = (c == flush_cyc);
            if (c == flush_cyc) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
            if (flush_cyc >= 0) begin
                if (c > flush_cyc + a_dly + d_dly + 4) break;
            end else if (mem_available) begin
                seen = 1;
                lat  = c;
                break;
            end
        end
        flush    = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        if (flush_cyc < 0) begin
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL timeout_pulse: addr %h got no mem_available, expected one", addr);
            end else if (exp_lat >= 0) begin
                checkOutput("latency", 32'(lat), 32'(exp_lat));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_available", 32'(mem_available), 32'd0);
        checkOutput("rst_r_data", mem_r_data, 32'd0);
        checkOutput("rst_req", 32'(data_sram_req), 32'd0);
        checkOutput("rst_wr", 32'(data_sram_wr), 32'd0);
        checkOutput("rst_size", 32'(data_sram_size), 32'd0);
        checkOutput("rst_addr", data_sram_addr, 32'd0);
        checkOutput("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
        checkOutput("rst_wdata", data_sram_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //            rd wr addr          wdata         sel      size a  d  rdata         flush lat
        applyStimulus(1, 0, 32'h8000_0010, 32'h0,        4'b1111, 2'd2, 0, 1, 32'hDEAD_BEEF, -1, 2);
        applyStimulus(0, 1, 32'h8000_0003, 32'h5A5A_5A5A, 4'b1000, 2'd0, 0, 1, 32'h0,        -1, -1);
        applyStimulus(0, 1, 32'h8000_0100, 32'h1122_3344, 4'b0111, 2'd2, 0, 1, 32'h0,        -1, -1);
        applyStimulus(0, 1, 32'h8000_0200, 32'hBEEF_BEEF, 4'b0011, 2'd1, 1, 2, 32'h0,        -1, -1);
        applyStimulus(1, 0, 32'h8000_0302, 32'h0,        4'b1100, 2'd1, 0, 3, 32'hCAFE_F00D, -1, 4);
        applyStimulus(1, 0, 32'h8000_0402, 32'h0,        4'b0100, 2'd0, 0, 0, 32'h0000_00A5, -1, 1);
        applyStimulus(1, 0, 32'h8000_0500, 32'h0,        4'b1111, 2'd2, 0, 5, 32'hBAD0_BAD0, 1,  -1);
        applyStimulus(1, 0, 32'h8000_0600, 32'h0,        4'b1111, 2'd2, 0, 1, 32'h1234_5678, -1, 2);
        applyStimulus(0, 1, 32'h8000_0700, 32'hA5A5_0F0F, 4'b1111, 2'd2, 10, 2, 32'h0,       -1, -1);
        applyStimulus(1, 1, 32'h8000_0800, 32'h7777_7777, 4'b1110, 2'd2, 0, 1, 32'h0,        -1, -1);
        applyStimulus(1, 0, 32'h8000_0904, 32'h0,        4'b1111, 2'd2, 2, 1, 32'h0BAD_F00D, -1, 4);

`ifdef DMEM_POSTED_WRITE_EN
        applyStimulus(0, 1, 32'h8000_0A00, 32'h600D_600D, 4'b1111, 2'd2, 0, 6, 32'h0,        -1, 1);
        applyStimulus(1, 0, 32'h8000_0A00, 32'h0,        4'b1111, 2'd2, 0, 1, 32'h600D_600D, -1, 7);
`endif

        // Reset in the middle of a stalled request drops req at once
        addr_delay = 20;
        bus_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h8000_0B00, wstrb: 4'b0000, wdata: 32'h0});
        @(negedge clk);
        mem_r_en = 1'b1;
        mem_addr = 32'h8000_0B00;
        mem_sel  = 4'b1111;
        repeat (3) @(negedge clk);
        checkOutput("mid_req_before_rst", 32'(data_sram_req), 32'd1);
        mem_r_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_req_after_rst", 32'(data_sram_req), 32'd0);
        checkOutput("mid_r_data_after_rst", mem_r_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        addr_delay = 0;
        repeat (3) @(negedge clk);

        checkOutput("bus_q_empty", 32'(bus_q.size()), 32'd0);
        checkOutput("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
